cnn_grid_engine: RTL and testbench

Parametrised cellular-neural-network grid engine: one time-multiplexed 3x3 cell update sweeps an ROWS x COLS state grid held in registers. Supports Jacobi or in-place (Gauss-Seidel) update order, an iteration cap and early stop on convergence, with streaming input load and streaming output readout. Sits between the image-input stream and the feature/result stream, superseding fixed-size 4x4 arrays.

---
 rtl/cnn_grid_engine.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_cnn_grid_engine.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_grid_engine.sv
// Cellular-neural-network grid engine: one time-multiplexed 3x3 cell update sweeps
// a ROWS x COLS register grid, with streaming load, Jacobi/Gauss-Seidel sweeps and streaming readout.
`timescale 1ns/1ps
module cnn_grid_engine #(
    parameter int unsigned WIDTH     = 9,
    parameter int unsigned ROWS      = 4,
    parameter int unsigned COLS      = 4,
    parameter int unsigned MAX_ITERS = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             gs_mode,
    input  logic [9*WIDTH-1:0]               a_tmpl,
    input  logic [9*WIDTH-1:0]               b_tmpl,
    input  logic [WIDTH-1:0]                 bias,
    input  logic [2*WIDTH-1:0]               x_init,
    input  logic                             u_valid,
    input  logic [WIDTH-1:0]                 u_data,
    output logic                             u_ready,
    output logic                             y_valid,
    output logic [WIDTH-1:0]                 y_data,
    input  logic                             y_ready,
    output logic                             busy,
    output logic                             done,
    output logic [$clog2(MAX_ITERS+1)-1:0]   iters_done
);

    localparam int unsigned F   = WIDTH - 2;
    localparam int unsigned ONE = 1 << F;
    localparam int unsigned N   = ROWS * COLS;
    localparam int unsigned KW  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CW  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned XW  = 2 * WIDTH;
    localparam int unsigned AW  = 2 * WIDTH + 5;
    localparam int unsigned SW  = AW + 1;
    localparam int unsigned IW  = $clog2(MAX_ITERS + 1);

    localparam logic signed [XW-1:0]    X_ONE  = XW'(ONE);
    localparam logic signed [XW-1:0]    X_MONE = -X_ONE;
    localparam logic signed [WIDTH-1:0] Y_ONE  = WIDTH'(ONE);
    localparam logic signed [WIDTH-1:0] Y_MONE = -Y_ONE;
    localparam logic signed [XW-1:0]    X_MAX  = {1'b0, {(XW-1){1'b1}}};
    localparam logic signed [XW-1:0]    X_MIN  = {1'b1, {(XW-1){1'b0}}};
    localparam logic signed [SW-1:0]    S_XMAX = SW'(X_MAX);
    localparam logic signed [SW-1:0]    S_XMIN = SW'(X_MIN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_SWEEP_END,
        S_OUT
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic signed [WIDTH-1:0] r_a [9];
    logic signed [WIDTH-1:0] r_b [9];
    logic signed [WIDTH-1:0] r_bias;
    logic signed [XW-1:0]    r_xinit;
    logic                    r_gs;

    logic signed [WIDTH-1:0] r_u    [N];
    logic signed [XW-1:0]    r_x    [N];
    logic signed [WIDTH-1:0] r_ycur [N];
    logic signed [WIDTH-1:0] r_ynxt [N];

    logic [KW-1:0]    r_k;
    logic [RW-1:0]    r_row;
    logic [CW-1:0]    r_col;
    logic             r_changed;
    logic [IW-1:0]    r_iters;
    logic             r_busy;
    logic             r_done;
    logic             r_u_ready;
    logic             r_y_valid;
    logic [WIDTH-1:0] r_y_data;

    logic                    w_last_k;
    logic                    w_u_acc;
    logic                    w_y_acc;
    logic                    w_stop;
    logic signed [AW-1:0]    w_acc;
    logic signed [AW-1:0]    w_sh;
    logic signed [SW-1:0]    w_sum;
    logic signed [XW-1:0]    w_xn;
    logic signed [WIDTH-1:0] w_yn;
    logic signed [WIDTH-1:0] w_yold;

    function automatic logic signed [WIDTH-1:0] clamp_y(input logic signed [XW-1:0] v);
        logic signed [WIDTH-1:0] res;
        if (v > X_ONE) begin
            res = Y_ONE;
        end else if (v < X_MONE) begin
            res = Y_MONE;
        end else begin
            res = WIDTH'(v);
        end
        return res;
    endfunction

    function automatic logic nbr_ok(input logic [RW-1:0] row, input logic [CW-1:0] col,
                                    input int dr, input int dc);
        int r;
        int c;
        r = int'(row) + dr - 1;
        c = int'(col) + dc - 1;
        return (r >= 0) && (r < int'(ROWS)) && (c >= 0) && (c < int'(COLS));
    endfunction

    function automatic logic [KW-1:0] nbr_idx(input logic [RW-1:0] row, input logic [CW-1:0] col,
                                              input int dr, input int dc);
        return KW'((int'(row) + dr - 1) * int'(COLS) + int'(col) + dc - 1);
    endfunction

    assign w_last_k = (r_k == KW'(N - 1));
    assign w_u_acc  = u_valid & r_u_ready;
    assign w_y_acc  = r_y_valid & y_ready;
    assign w_stop   = !r_changed || ((r_iters + IW'(1)) == IW'(MAX_ITERS));

    // 3x3 weighted sum over current cell; out-of-grid neighbours are simply skipped (zero padding)
    always_comb begin
        w_acc = '0;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                if (nbr_ok(r_row, r_col, dr, dc)) begin
                    w_acc = w_acc
                          + AW'(r_a[4'(dr*3+dc)]) * AW'(r_ycur[nbr_idx(r_row, r_col, dr, dc)])
                          + AW'(r_b[4'(dr*3+dc)]) * AW'(r_u[nbr_idx(r_row, r_col, dr, dc)]);
                end
            end
        end
    end

    // Rescale, add bias, saturate to the state width, then clamp to the output range
    always_comb begin
        w_sh  = w_acc >>> F;
        w_sum = SW'(w_sh) + SW'(r_bias);
        if (w_sum > S_XMAX) begin
            w_xn = X_MAX;
        end else if (w_sum < S_XMIN) begin
            w_xn = X_MIN;
        end else begin
            w_xn = XW'(w_sum);
        end
        w_yn = clamp_y(w_xn);
    end

    // X always holds the unclamped value behind the cell's Y of the previous sweep
    assign w_yold = clamp_y(r_x[r_k]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (start) w_state_nxt = S_LOAD;
            S_LOAD:      if (w_u_acc && w_last_k) w_state_nxt = S_RUN;
            S_RUN:       if (w_last_k) w_state_nxt = S_SWEEP_END;
            S_SWEEP_END: w_state_nxt = w_stop ? S_OUT : S_RUN;
            S_OUT:       if (w_y_acc && w_last_k) w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int j = 0; j < 9; j++) begin
                r_a[4'(j)] <= '0;
                r_b[4'(j)] <= '0;
            end
            for (int i = 0; i < int'(N); i++) begin
                r_u[KW'(i)]    <= '0;
                r_x[KW'(i)]    <= '0;
                r_ycur[KW'(i)] <= '0;
                r_ynxt[KW'(i)] <= '0;
            end
            r_bias    <= '0;
            r_xinit   <= '0;
            r_gs      <= 1'b0;
            r_k       <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_changed <= 1'b0;
            r_iters   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_u_ready <= 1'b0;
            r_y_valid <= 1'b0;
            r_y_data  <= '0;
        end else begin
            r_done    <= 1'b0;
            r_busy    <= (w_state_nxt != S_IDLE);
            r_u_ready <= (w_state_nxt == S_LOAD);
            r_y_valid <= (w_state_nxt == S_OUT);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        for (int j = 0; j < 9; j++) begin
                            r_a[4'(j)] <= a_tmpl[j*WIDTH +: WIDTH];
                            r_b[4'(j)] <= b_tmpl[j*WIDTH +: WIDTH];
                        end
                        r_bias  <= bias;
                        r_xinit <= x_init;
                        r_gs    <= gs_mode;
                        r_iters <= '0;
                        r_k     <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_u_acc) begin
                        r_u[r_k]    <= u_data;
                        r_x[r_k]    <= r_xinit;
                        r_ycur[r_k] <= clamp_y(r_xinit);
                        if (w_last_k) begin
                            r_k       <= '0;
                            r_row     <= '0;
                            r_col     <= '0;
                            r_changed <= 1'b0;
                        end else begin
                            r_k <= r_k + KW'(1);
                        end
                    end
                end
                S_RUN: begin
                    r_x[r_k] <= w_xn;
                    if (r_gs) begin
                        r_ycur[r_k] <= w_yn;
                    end else begin
                        r_ynxt[r_k] <= w_yn;
                    end
                    if (w_yn != w_yold) begin
                        r_changed <= 1'b1;
                    end
                    if (w_last_k) begin
                        r_k   <= '0;
                        r_row <= '0;
                        r_col <= '0;
                    end else begin
                        r_k <= r_k + KW'(1);
                        if (r_col == CW'(COLS - 1)) begin
                            r_col <= '0;
                            r_row <= r_row + RW'(1);
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                    end
                end
                S_SWEEP_END: begin
                    if (!r_gs) begin
                        for (int i = 0; i < int'(N); i++) begin
                            r_ycur[KW'(i)] <= r_ynxt[KW'(i)];
                        end
                    end
                    r_iters <= r_iters + IW'(1);
                    if (w_stop) begin
                        // first readout word must already see this sweep's Jacobi result
                        r_y_data <= r_gs ? r_ycur[0] : r_ynxt[0];
                        r_k      <= '0;
                    end else begin
                        r_changed <= 1'b0;
                    end
                end
                S_OUT: begin
                    if (w_y_acc) begin
                        if (w_last_k) begin
                            r_k    <= '0;
                            r_done <= 1'b1;
                        end else begin
                            r_k      <= r_k + KW'(1);
                            r_y_data <= r_ycur[r_k + KW'(1)];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign u_ready    = r_u_ready;
    assign y_valid    = r_y_valid;
    assign y_data     = r_y_data;
    assign busy       = r_busy;
    assign done       = r_done;
    assign iters_done = r_iters;

endmodule

// File: tb/tb_cnn_grid_engine.sv
// Bench for cnn_grid_engine: directed and random jobs scored against an array-based
// reference of the cell equations, plus reset and handshake behaviour.
`timescale 1ns/1ps
module tb_cnn_grid_engine;

    localparam int W  = 9;
    localparam int R  = 4;
    localparam int C  = 4;
    localparam int N  = R * C;
    localparam int MI = 16;
    localparam int IW = 5;
    localparam int F  = W - 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            gs_mode;
    logic [9*W-1:0]  a_tmpl;
    logic [9*W-1:0]  b_tmpl;
    logic [W-1:0]    bias;
    logic [2*W-1:0]  x_init;
    logic            u_valid;
    logic [W-1:0]    u_data;
    logic            u_ready;
    logic            y_valid;
    logic [W-1:0]    y_data;
    logic            y_ready;
    logic            busy;
    logic            done;
    logic [IW-1:0]   iters_done;

    always #5 clk = ~clk;

    cnn_grid_engine #(.WIDTH(W), .ROWS(R), .COLS(C), .MAX_ITERS(MI)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .gs_mode(gs_mode),
        .a_tmpl(a_tmpl), .b_tmpl(b_tmpl), .bias(bias), .x_init(x_init),
        .u_valid(u_valid), .u_data(u_data), .u_ready(u_ready),
        .y_valid(y_valid), .y_data(y_data), .y_ready(y_ready),
        .busy(busy), .done(done), .iters_done(iters_done)
    );

    int total = 0;
    int bad   = 0;

    int m_a [9];
    int m_b [9];
    int m_u [N];
    int m_bias;
    int m_xinit;
    bit m_gs;
    int exp_y [N];
    int exp_it;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int clampi(input longint v, input longint lo, input longint hi);
        if (v < lo) return int'(lo);
        if (v > hi) return int'(hi);
        return int'(v);
    endfunction

    // Whole-grid sweeps with plain integer arithmetic
    function automatic void model();
        int y  [N];
        int yn [N];
        longint acc;
        longint xs;
        int nv;
        bit ch;
        for (int k = 0; k < N; k++) y[k] = clampi(m_xinit, -(1 << F), 1 << F);
        exp_it = 0;
        for (int it = 1; it <= MI; it++) begin
            ch = 0;
            yn = y;
            for (int r = 0; r < R; r++) begin
                for (int c = 0; c < C; c++) begin
                    acc = 0;
                    for (int dr = -1; dr <= 1; dr++) begin
                        for (int dc = -1; dc <= 1; dc++) begin
                            if (r+dr >= 0 && r+dr < R && c+dc >= 0 && c+dc < C) begin
                                acc += longint'(m_a[(dr+1)*3 + dc+1])
                                     * longint'(m_gs ? yn[(r+dr)*C + c+dc] : y[(r+dr)*C + c+dc]);
                                acc += longint'(m_b[(dr+1)*3 + dc+1]) * longint'(m_u[(r+dr)*C + c+dc]);
                            end
                        end
                    end
                    xs = (acc >>> F) + longint'(m_bias);
                    nv = clampi(clampi(xs, -(1 << (2*W-1)), (1 << (2*W-1)) - 1), -(1 << F), 1 << F);
                    if (nv != y[r*C + c]) ch = 1;
                    yn[r*C + c] = nv;
                end
            end
            y = yn;
            exp_it = it;
            if (!ch) break;
        end
        exp_y = y;
    endfunction

    task automatic clr_cfg();
        for (int j = 0; j < 9; j++) begin
            m_a[j] = 0;
            m_b[j] = 0;
        end
        for (int k = 0; k < N; k++) m_u[k] = 0;
        m_bias = 0;
        m_xinit = 0;
        m_gs = 0;
    endtask

    task automatic apply_cfg();
        for (int j = 0; j < 9; j++) begin
            a_tmpl[j*W +: W] = W'(m_a[j]);
            b_tmpl[j*W +: W] = W'(m_b[j]);
        end
        bias    = W'(m_bias);
        x_init  = (2*W)'(m_xinit);
        gs_mode = m_gs;
    endtask

    task automatic run_job(input string name, input bit gaps, input bit ystall,
                           input bit inj_start, input int exp_busy);
        int ui;
        int yi;
        int nb;
        int cyc;
        bit got;
        bit stalled;
        logic [W-1:0] held;
        model();
        apply_cfg();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        ui = 0; yi = 0; nb = 0; cyc = 0; got = 0; stalled = 0; held = '0;
        while (!got && cyc < 4000) begin
            start = 1'b0;
            if (done) begin
                got = 1;
            end else begin
                if (busy) nb++;
                if (ui < N) begin
                    chk({name, "_u_ready"}, 32'(u_ready), 1);
                    u_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
                    u_data  = W'(m_u[ui]);
                    if (u_valid && u_ready) ui++;
                end else begin
                    u_valid = 1'b0;
                    u_data  = W'($urandom);
                end
                if (y_valid) begin
                    if (stalled) chk({name, "_y_stable"}, 32'(y_data), 32'(held));
                    if (yi < N) chk({name, "_y_word"}, 32'($signed(y_data)), exp_y[yi]);
                    else        chk({name, "_y_overrun"}, yi, N - 1);
                    y_ready = ystall ? ($urandom_range(0, 1) == 1) : 1'b1;
                    if (y_ready) begin
                        yi++;
                        stalled = 0;
                    end else begin
                        stalled = 1;
                        held = y_data;
                    end
                end else begin
                    y_ready = ystall ? ($urandom_range(0, 1) == 1) : 1'b1;
                    stalled = 0;
                end
                if (inj_start && ui == N && !y_valid && yi == 0 && busy && $urandom_range(0, 3) == 0)
                    start = 1'b1;
                @(negedge clk);
                cyc++;
            end
        end
        start   = 1'b0;
        u_valid = 1'b0;
        y_ready = 1'b1;
        chk({name, "_done_seen"}, 32'(got), 1);
        chk({name, "_words"}, yi, N);
        chk({name, "_iters"}, 32'(iters_done), exp_it);
        chk({name, "_busy_low"}, 32'(busy), 0);
        chk({name, "_y_valid_low"}, 32'(y_valid), 0);
        if (exp_busy > 0) chk({name, "_busy_cycles"}, nb, exp_busy);
        @(negedge clk);
        chk({name, "_done_pulse"}, 32'(done), 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; gs_mode = 1'b0; a_tmpl = '0; b_tmpl = '0;
        bias = '0; x_init = '0; u_valid = 1'b0; u_data = '0; y_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_u_ready", 32'(u_ready), 0);
        chk("rst_y_valid", 32'(y_valid), 0);
        chk("rst_y_data", 32'(y_data), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_iters", 32'(iters_done), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // constant pass-through with exact busy length
        clr_cfg();
        m_b[4] = 128;
        for (int k = 0; k < N; k++) m_u[k] = 64;
        run_job("pass", 0, 0, 0, 16 + 2*17 + 16);

        // positive saturation
        clr_cfg();
        m_b[4] = 127; m_bias = 127;
        for (int k = 0; k < N; k++) m_u[k] = 127;
        run_job("sat_pos", 0, 0, 0, 0);

        // negative saturation
        clr_cfg();
        m_bias = -128;
        for (int k = 0; k < N; k++) m_u[k] = 127;
        run_job("sat_neg", 0, 0, 0, 0);

        // zero padding at edges and corners
        clr_cfg();
        for (int j = 0; j < 9; j++) m_b[j] = 8;
        for (int k = 0; k < N; k++) m_u[k] = 128;
        run_job("pad", 0, 0, 0, 0);

        // west-feedback propagation in both update orders
        clr_cfg();
        m_a[3] = 128; m_b[4] = 128; m_u[12] = 64; m_gs = 1;
        run_job("west_gs", 0, 0, 0, 0);
        m_gs = 0;
        run_job("west_jac", 1, 1, 0, 0);

        // self-inhibition oscillates and must hit the sweep cap
        clr_cfg();
        m_a[4] = -128; m_bias = 64;
        run_job("cap", 0, 1, 1, 0);

        // random templates, gaps, backpressure and stray start pulses
        for (int t = 0; t < 6; t++) begin
            clr_cfg();
            m_gs = t[0];
            for (int j = 0; j < 9; j++) begin
                m_a[j] = int'($urandom_range(0, 256)) - 128;
                m_b[j] = int'($urandom_range(0, 256)) - 128;
            end
            for (int k = 0; k < N; k++) m_u[k] = int'($urandom_range(0, 511)) - 256;
            m_bias  = int'($urandom_range(0, 200)) - 100;
            m_xinit = int'($urandom_range(0, 600)) - 300;
            run_job("rand", 1, 1, 1, 0);
        end

        // reset in the middle of RUN aborts without a done pulse
        clr_cfg();
        m_a[4] = -128; m_bias = 64;
        apply_cfg();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            u_valid = 1'b1;
            u_data  = '0;
            @(negedge clk);
        end
        u_valid = 1'b0;
        repeat (59) @(negedge clk);
        chk("mid_iters", 32'(iters_done), 3);
        chk("mid_busy", 32'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_u_ready", 32'(u_ready), 0);
        chk("abort_y_valid", 32'(y_valid), 0);
        chk("abort_iters", 32'(iters_done), 0);
        chk("abort_done", 32'(done), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
